// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving one shared tri-state bus from N producer channels.
// A one-cycle high-Z turnaround separates owners, and an optional hold limit preempts long owners.
module tri_bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clock,
  input  logic                 reset_b,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 bus_en,
  output logic [W-1:0]         bus_out
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t          state, state_n;
  logic [N-1:0]    grant_n;
  logic [IW-1:0]   idx_n;
  logic            bus_en_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [IW-1:0]   win;
  logic            found;
  logic            others;
  logic            hold_hit;

  // Round-robin search starting at ptr, wrapping modulo N
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int cand;
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  assign others   = |(req & ~grant);
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1)) && others;

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    idx_n    = grant_idx;
    bus_en_n = bus_en;
    ptr_n    = ptr;
    hold_n   = hold_cnt;
    case (state)
      IDLE, TURN: begin
        if (found) begin
          state_n  = GRANT;
          grant_n  = N'(1) << win;
          idx_n    = win;
          bus_en_n = 1'b1;
          hold_n   = '0;
        end else begin
          state_n  = IDLE;
          grant_n  = '0;
          idx_n    = '0;
          bus_en_n = 1'b0;
        end
      end
      GRANT: begin
        if (!req[grant_idx] || hold_hit) begin
          state_n  = TURN;
          grant_n  = '0;
          idx_n    = '0;
          bus_en_n = 1'b0;
          ptr_n    = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end else if (hold_cnt != HW'(MAX_HOLD)) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        grant_n  = '0;
        idx_n    = '0;
        bus_en_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      bus_en    <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      bus_en    <= bus_en_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
    end
  end

  // Data path has no register so the owner's data reaches the bus in the same cycle
  assign bus_out = bus_en ? data_in[grant_idx*W +: W] : {W{1'bz}};

endmodule
